// File: rtl/reg_file_param.sv
// Parameterised two-read/one-write register file with a post-reset clear sweep and a
// one-entry deferred-write buffer for memory stalls. Define REG_FILE_BYPASS_EN for write-through reads.
module reg_file_param #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 3
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              WRITE,
    input  logic              BUSYWAIT,
    input  logic [ADDR_W-1:0] INADDRESS,
    input  logic [DATA_W-1:0] IN,
    input  logic [ADDR_W-1:0] OUT1ADDRESS,
    input  logic [ADDR_W-1:0] OUT2ADDRESS,
    output logic [DATA_W-1:0] OUT1,
    output logic [DATA_W-1:0] OUT2,
    output logic              READY,
    output logic              PENDING
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] LastIdx = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] CntOne  = (ADDR_W + 1)'(1);

    typedef enum logic [1:0] {StClear, StRun, StHold} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W:0]     clr_cnt_q, clr_cnt_d;
    logic                pend_q, pend_d;
    logic [ADDR_W-1:0]   pend_addr_q, pend_addr_d;
    logic [DATA_W-1:0]   pend_data_q, pend_data_d;

    logic                we;
    logic [ADDR_W-1:0]   waddr;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W-1:0]   regs_q [DEPTH];

    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        pend_d      = pend_q;
        pend_addr_d = pend_addr_q;
        pend_data_d = pend_data_q;
        we          = 1'b0;
        waddr       = INADDRESS;
        wdata       = IN;
        unique case (state_q)
            StClear: begin
                we        = 1'b1;
                waddr     = clr_cnt_q[ADDR_W-1:0];
                wdata     = '0;
                clr_cnt_d = clr_cnt_q + CntOne;
                if (clr_cnt_q == LastIdx) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (WRITE) begin
                    if (BUSYWAIT) begin
                        pend_d      = 1'b1;
                        pend_addr_d = INADDRESS;
                        pend_data_d = IN;
                        state_d     = StHold;
                    end else begin
                        we = 1'b1;
                    end
                end
            end
            StHold: begin
                if (!BUSYWAIT) begin
                    // A live write supersedes the held one; otherwise drain the buffer.
                    we = 1'b1;
                    if (!WRITE) begin
                        waddr = pend_addr_q;
                        wdata = pend_data_q;
                    end
                    pend_d  = 1'b0;
                    state_d = StRun;
                end else if (WRITE) begin
                    pend_addr_d = INADDRESS;
                    pend_data_d = IN;
                end
            end
            default: begin
                state_d = StClear;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q     <= StClear;
            clr_cnt_q   <= '0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            pend_data_q <= '0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            pend_data_q <= pend_data_d;
        end
    end

    // Storage is left untouched during reset; the sweep clears it once RESET releases.
    always_ff @(posedge CLK) begin
        if (RESET && we) begin
            regs_q[waddr] <= wdata;
        end
    end

    always_comb begin
        OUT1    = '0;
        OUT2    = '0;
        READY   = 1'b0;
        PENDING = 1'b0;
        if (RESET && (state_q != StClear)) begin
            OUT1    = regs_q[OUT1ADDRESS];
            OUT2    = regs_q[OUT2ADDRESS];
            READY   = 1'b1;
            PENDING = pend_q;
`ifdef REG_FILE_BYPASS_EN
            if (WRITE && !BUSYWAIT && (OUT1ADDRESS == INADDRESS)) begin
                OUT1 = IN;
            end
            if (WRITE && !BUSYWAIT && (OUT2ADDRESS == INADDRESS)) begin
                OUT2 = IN;
            end
`else
`endif
        end
    end

endmodule

// File: tb/tb_reg_file_param.sv
// Scoreboard bench for reg_file_param: stimulus queues expected outputs per cycle,
// a negedge monitor pops and compares them.
module tb_reg_file_param;

    logic       CLK = 1'b0;
    logic       RESET, WRITE, BUSYWAIT;
    logic [2:0] INADDRESS, OUT1ADDRESS, OUT2ADDRESS;
    logic [7:0] IN, OUT1, OUT2;
    logic       READY, PENDING;

    reg_file_param #(.DATA_W(8), .ADDR_W(3)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .WRITE      (WRITE),
        .BUSYWAIT   (BUSYWAIT),
        .INADDRESS  (INADDRESS),
        .IN         (IN),
        .OUT1ADDRESS(OUT1ADDRESS),
        .OUT2ADDRESS(OUT2ADDRESS),
        .OUT1       (OUT1),
        .OUT2       (OUT2),
        .READY      (READY),
        .PENDING    (PENDING)
    );

    always #5 CLK = ~CLK;

`ifdef REG_FILE_BYPASS_EN
    localparam bit Bypass = 1'b1;
`else
    localparam bit Bypass = 1'b0;
`endif

    typedef struct {
        string      name;
        logic [7:0] o1;
        logic [7:0] o2;
        logic       rdy;
        logic       pnd;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;

    task automatic push(input string n, input logic [7:0] o1, input logic [7:0] o2,
                        input logic r, input logic p);
        exp_t e;
        e.name = n;
        e.o1   = o1;
        e.o2   = o2;
        e.rdy  = r;
        e.pnd  = p;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Monitor: outputs are stable mid-cycle, one expectation per cycle.
    always @(negedge CLK) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (OUT1 === e.o1 && OUT2 === e.o2 && READY === e.rdy && PENDING === e.pnd) begin
                passes++;
            end else begin
                $display("FAIL %s: got OUT1=%h OUT2=%h READY=%b PENDING=%b, want %h %h %b %b",
                         e.name, OUT1, OUT2, READY, PENDING, e.o1, e.o2, e.rdy, e.pnd);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "timeout");
    end

    initial begin
        RESET = 1'b0; WRITE = 1'b0; BUSYWAIT = 1'b0;
        INADDRESS = '0; IN = '0; OUT1ADDRESS = 3'd0; OUT2ADDRESS = 3'd1;
        tick(); tick();
        push("initial_reset", 8'h00, 8'h00, 1'b0, 1'b0);
        RESET = 1'b1;
        repeat (8) tick();

        // Fill with junk, then confirm a couple of values landed.
        for (int i = 0; i < 8; i++) begin
            WRITE = 1'b1; INADDRESS = 3'(i); IN = 8'hC0 + 8'(i);
            tick();
        end
        WRITE = 1'b0; OUT1ADDRESS = 3'd7; OUT2ADDRESS = 3'd0;
        push("junk_loaded", 8'hC7, 8'hC0, 1'b1, 1'b0);
        tick();

        // Reset sweep: READY rises exactly on the 8th edge after release.
        RESET = 1'b0;
        tick();
        tick();
        push("reset_held", 8'h00, 8'h00, 1'b0, 1'b0);
        RESET = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            push($sformatf("sweep_%0d", i), 8'h00, 8'h00, (i == 8), 1'b0);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            OUT1ADDRESS = 3'(i); OUT2ADDRESS = 3'(i + 4);
            push($sformatf("cleared_%0d", i), 8'h00, 8'h00, 1'b1, 1'b0);
        end
        tick();

        // Plain write.
        WRITE = 1'b1; INADDRESS = 3'd3; IN = 8'hA5; OUT1ADDRESS = 3'd3; OUT2ADDRESS = 3'd2;
        tick();
        WRITE = 1'b0;
        push("plain_write", 8'hA5, 8'h00, 1'b1, 1'b0);
        tick();

        // Deferred write, last load wins.
        BUSYWAIT = 1'b1; WRITE = 1'b1; INADDRESS = 3'd5; IN = 8'h11; OUT1ADDRESS = 3'd5;
        tick();
        IN = 8'h22;
        push("defer_hold1", 8'h00, 8'h00, 1'b1, 1'b1);
        tick();
        WRITE = 1'b0; BUSYWAIT = 1'b0;
        push("defer_hold2", 8'h00, 8'h00, 1'b1, 1'b1);
        tick();
        push("defer_commit", 8'h22, 8'h00, 1'b1, 1'b0);
        tick();

        // Supersede: live write replaces the held entry.
        BUSYWAIT = 1'b1; WRITE = 1'b1; INADDRESS = 3'd4; IN = 8'h33;
        tick();
        BUSYWAIT = 1'b0; INADDRESS = 3'd6; IN = 8'h44; OUT1ADDRESS = 3'd6; OUT2ADDRESS = 3'd4;
        push("supersede_pre", Bypass ? 8'h44 : 8'h00, 8'h00, 1'b1, 1'b1);
        tick();
        WRITE = 1'b0;
        push("supersede_post", 8'h44, 8'h00, 1'b1, 1'b0);
        tick();

        // Same-cycle forwarding.
        WRITE = 1'b1; INADDRESS = 3'd2; IN = 8'h5A; OUT1ADDRESS = 3'd2; OUT2ADDRESS = 3'd3;
        push("bypass_pre", Bypass ? 8'h5A : 8'h00, 8'hA5, 1'b1, 1'b0);
        tick();
        WRITE = 1'b0;
        push("bypass_post", 8'h5A, 8'hA5, 1'b1, 1'b0);
        tick();

        // Reset while a write is held; writes during the sweep must be ignored.
        BUSYWAIT = 1'b1; WRITE = 1'b1; INADDRESS = 3'd1; IN = 8'hFF; OUT1ADDRESS = 3'd1;
        tick();
        WRITE = 1'b0;
        push("hold_before_rst", 8'h00, 8'hA5, 1'b1, 1'b1);
        tick();
        RESET = 1'b0; BUSYWAIT = 1'b0;
        tick();
        push("rst_mid_hold", 8'h00, 8'h00, 1'b0, 1'b0);
        RESET = 1'b1; WRITE = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i == 8) WRITE = 1'b0;
            push($sformatf("resweep_%0d", i), 8'h00, 8'h00, (i == 8), 1'b0);
        end
        tick();
        OUT1ADDRESS = 3'd1; OUT2ADDRESS = 3'd6;
        push("reg1_never_ff", 8'h00, 8'h00, 1'b1, 1'b0);
        tick();
        tick();

        if (exp_q.size() != 0) begin
            checks++;
            $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/reg_file_param.md
REG_FILE_PARAM -- requirements
Module: reg_file_param

Interface
REQ-001 SHALL have parameter DATA_W, default 8, register data width in bits.
REQ-002 SHALL have parameter ADDR_W, default 3, address width; DEPTH = 2**ADDR_W registers.
REQ-003 SHALL have port CLK  input  1  single clock; all state changes on posedge CLK.
REQ-004 SHALL have port RESET  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port WRITE  input  1  write request for INADDRESS.
REQ-006 SHALL have port BUSYWAIT  input  1  memory stall; defers writes while high.
REQ-007 SHALL have port INADDRESS  input  ADDR_W  write address.
REQ-008 SHALL have port IN  input  DATA_W  write data.
REQ-009 SHALL have ports OUT1ADDRESS, OUT2ADDRESS  input  ADDR_W  read addresses.
REQ-010 SHALL have ports OUT1, OUT2  output  DATA_W  read data.
REQ-011 SHALL have port READY  output  1  high when clear sweep is done and the file accepts writes.
REQ-012 SHALL have port PENDING  output  1  high while a deferred write is held.

Function
REQ-013 SHALL implement states CLEAR, RUN, HOLD, plus a counter clr_cnt (ADDR_W+1 bits), pending buffer pend_addr/pend_data and flag PEND.
REQ-014 SHALL, in CLEAR with RESET high, zero reg[clr_cnt] each posedge and increment clr_cnt; on the posedge zeroing reg[DEPTH-1], go to RUN and set READY.
REQ-015 SHALL ignore WRITE in CLEAR; OUT1/OUT2 SHALL read 0 in CLEAR.
REQ-016 SHALL provide combinational, zero-latency reads: OUTn = reg[OUTnADDRESS] in RUN and HOLD.
REQ-017 SHALL, in RUN, on posedge with WRITE=1 and BUSYWAIT=0, write IN to reg[INADDRESS]; new value visible on reads after that edge.
REQ-018 SHALL, in RUN or HOLD, on posedge with WRITE=1 and BUSYWAIT=1, load pend_addr/pend_data from INADDRESS/IN, set PEND, enter HOLD; a later load while held overwrites (last wins).
REQ-019 SHALL, in HOLD, on posedge with BUSYWAIT=0: if WRITE=1 write live IN/INADDRESS and discard the pending entry; else commit pend_data to reg[pend_addr]; then clear PEND, go to RUN.
REQ-020 SHALL, in HOLD with BUSYWAIT=1 and WRITE=0, keep the pending entry unchanged.
REQ-021 SHALL drive PENDING = PEND; PEND high only in HOLD.
REQ-022 SHALL never perform more than one register write per cycle; reads of a held address return the old value until commit.

Reset
REQ-023 SHALL, on any posedge with RESET=0, enter CLEAR, set clr_cnt=0, PEND=0, READY=0, discarding any pending write, regardless of current state.
REQ-024 SHALL hold reset values while RESET=0: READY=0, PENDING=0, OUT1=OUT2=0; register contents are not swept until RESET returns high.
REQ-025 SHALL assert READY exactly DEPTH posedges after the first posedge sampling RESET=1.

Configuration
REQ-026 SHALL support macro REG_FILE_BYPASS_EN.
REQ-027 SHALL, with REG_FILE_BYPASS_EN defined, drive OUTn = IN when state is RUN or HOLD, WRITE=1, BUSYWAIT=0 and OUTnADDRESS=INADDRESS (same-cycle write-through forwarding).
REQ-028 SHALL, without REG_FILE_BYPASS_EN, always return stored contents; a written value appears only after the write edge.

Verification
REQ-029 Reset sweep: preload junk, RESET=0 2 cycles then 1 -> READY low for 8 posedges (default), high on 8th; all 8 registers read 0.
REQ-030 Plain write: RUN, WRITE=1, INADDRESS=3, IN=8'hA5, BUSYWAIT=0 -> after edge OUT1ADDRESS=3 reads 8'hA5; OUT2ADDRESS=2 still 0.
REQ-031 Deferred write: BUSYWAIT=1, WRITE=1 addr 5 data 8'h11 then addr 5 data 8'h22, then WRITE=0, BUSYWAIT=0 -> PENDING high 2 cycles, reg5 stays 0, then reads 8'h22, PENDING low.
REQ-032 Supersede: HOLD with pending addr 4 data 8'h33; BUSYWAIT=0, WRITE=1 addr 6 data 8'h44 -> reg6=8'h44, reg4 unchanged 0, PENDING low.
REQ-033 Reset mid-HOLD: pending addr 1 data 8'hFF, RESET=0 one cycle -> PENDING=0, READY=0, reg1 never becomes 8'hFF; sweep restarts from 0.
REQ-034 Bypass: WRITE=1 addr 2 data 8'h5A, OUT1ADDRESS=2, BUSYWAIT=0 -> before edge OUT1=8'h5A with REG_FILE_BYPASS_EN, old value without.
